// File: rtl/riscv_test_monitor.sv
// Watches a RISC-V core's writeback/store ports for the test-end handshake, then reports pass/fail/timeout.
// Latency: end trigger -> done after DRAIN_CYCLES enabled cycles; no backpressure, status is sticky until reset.
module riscv_test_monitor #(
    parameter int          XLEN           = 32,
    parameter int          MODE           = 0,
    parameter int          END_REG        = 26,
    parameter int          RES_REG        = 27,
    parameter int          NUM_REG        = 3,
    parameter logic [31:0] END_ADDR       = 32'h10,
    parameter int          DRAIN_CYCLES   = 10,
    parameter int          TIMEOUT_CYCLES = 3000,
    parameter int          CNT_W          = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_b,
    input  logic             i_enable,
    input  logic             i_wb_en,
    input  logic [4:0]       i_wb_addr,
    input  logic [XLEN-1:0]  i_wb_data,
    input  logic             i_st_en,
    input  logic [XLEN-1:0]  i_st_addr,
    input  logic [XLEN-1:0]  i_st_data,
    input  logic             i_retire,
    output logic             o_done,
    output logic             o_pass,
    output logic             o_fail,
    output logic             o_timeout,
    output logic [XLEN-1:0]  o_testnum,
    output logic [CNT_W-1:0] o_cycle_cnt,
    output logic [CNT_W-1:0] o_retire_cnt
);

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE, S_TOUT} state_t;

    localparam logic [4:0]       L_END_REG  = END_REG[4:0];
    localparam logic [4:0]       L_RES_REG  = RES_REG[4:0];
    localparam logic [4:0]       L_NUM_REG  = NUM_REG[4:0];
    localparam logic [XLEN-1:0]  L_END_ADDR = XLEN'(END_ADDR);
    localparam logic [XLEN-1:0]  L_ONE      = XLEN'(1);
    localparam logic [7:0]       L_DRAIN    = 8'(DRAIN_CYCLES);
    localparam logic [CNT_W-1:0] L_TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t            r_state,     w_state_nxt;
    logic [7:0]        r_drain,     w_drain_nxt;
    logic [XLEN-1:0]   r_result,    w_result_nxt;
    logic [XLEN-1:0]   r_testnum,   w_testnum_nxt;
    logic [CNT_W-1:0]  r_cycle_cnt, w_cycle_nxt;
    logic [CNT_W-1:0]  r_retire_cnt, w_retire_nxt;
    logic              r_done, r_pass, r_fail, r_timeout;
    logic              w_done_nxt, w_pass_nxt, w_fail_nxt, w_timeout_nxt;
    logic              w_shadow_ok, w_wb_ok, w_trig, w_tout_hit;

    // Shadows track the core until the verdict is latched; x0 writes never land.
    assign w_shadow_ok   = (r_state == S_IDLE) || (r_state == S_RUN) || (r_state == S_DRAIN);
    assign w_wb_ok       = w_shadow_ok && i_wb_en && (i_wb_addr != 5'd0);
    assign w_result_nxt  = (w_wb_ok && i_wb_addr == L_RES_REG) ? i_wb_data : r_result;
    assign w_testnum_nxt = (w_wb_ok && i_wb_addr == L_NUM_REG) ? i_wb_data : r_testnum;

    assign w_trig = (MODE == 0)
        ? (i_wb_en && i_wb_addr == L_END_REG && i_wb_data == L_ONE)
        : (i_st_en && i_st_addr == L_END_ADDR && i_st_data == L_ONE);

    // ">=" so an end trigger landing on the last cycle still times out from DRAIN.
    assign w_tout_hit = i_enable && (r_cycle_cnt >= L_TO_LAST);

    always_comb begin
        w_state_nxt   = r_state;
        w_drain_nxt   = r_drain;
        w_cycle_nxt   = r_cycle_cnt;
        w_retire_nxt  = r_retire_cnt;
        w_done_nxt    = r_done;
        w_pass_nxt    = r_pass;
        w_fail_nxt    = r_fail;
        w_timeout_nxt = r_timeout;

        if (i_enable && (r_state == S_RUN || r_state == S_DRAIN)) begin
            if (r_cycle_cnt != '1) w_cycle_nxt = r_cycle_cnt + 1'b1;
            if (i_retire && r_retire_cnt != '1) w_retire_nxt = r_retire_cnt + 1'b1;
        end

        case (r_state)
            S_IDLE: begin
                if (i_enable) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (i_enable && w_trig) begin
                    w_state_nxt = S_DRAIN;
                    w_drain_nxt = L_DRAIN;
                end else if (w_tout_hit) begin
                    w_state_nxt   = S_TOUT;
                    w_done_nxt    = 1'b1;
                    w_timeout_nxt = 1'b1;
                end
            end
            S_DRAIN: begin
                if (w_tout_hit) begin
                    w_state_nxt   = S_TOUT;
                    w_done_nxt    = 1'b1;
                    w_timeout_nxt = 1'b1;
                end else if (i_enable) begin
                    w_drain_nxt = r_drain - 8'd1;
                    if (r_drain <= 8'd1) begin
                        w_state_nxt = S_DONE;
                        w_done_nxt  = 1'b1;
                        w_pass_nxt  = (MODE == 0) ? (w_result_nxt == L_ONE) : 1'b1;
                        w_fail_nxt  = (MODE == 0) ? (w_result_nxt != L_ONE) : 1'b0;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_b) begin
            r_state      <= S_IDLE;
            r_drain      <= '0;
            r_result     <= '0;
            r_testnum    <= '0;
            r_cycle_cnt  <= '0;
            r_retire_cnt <= '0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_fail       <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_drain      <= w_drain_nxt;
            r_result     <= w_result_nxt;
            r_testnum    <= w_testnum_nxt;
            r_cycle_cnt  <= w_cycle_nxt;
            r_retire_cnt <= w_retire_nxt;
            r_done       <= w_done_nxt;
            r_pass       <= w_pass_nxt;
            r_fail       <= w_fail_nxt;
            r_timeout    <= w_timeout_nxt;
        end
    end

    assign o_done       = r_done;
    assign o_pass       = r_pass;
    assign o_fail       = r_fail;
    assign o_timeout    = r_timeout;
    assign o_testnum    = r_testnum;
    assign o_cycle_cnt  = r_cycle_cnt;
    assign o_retire_cnt = r_retire_cnt;

endmodule

// File: tb/tb_riscv_test_monitor.sv
// Bench for riscv_test_monitor: directed end-of-test scenarios plus random traffic against a reference model.
module tb_riscv_test_monitor;

    localparam int TO = 3000;
    localparam int DC = 10;
    localparam int P_IDLE = 0, P_RUN = 1, P_DRAIN = 2, P_DONE = 3, P_TOUT = 4;

    logic        clk = 1'b0;
    logic        rst_b, enable, wb_en, st_en, retire;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data, st_addr, st_data;

    logic        d0_done, d0_pass, d0_fail, d0_to, d1_done, d1_pass, d1_fail, d1_to;
    logic [31:0] d0_tnum, d0_cyc, d0_ret, d1_tnum, d1_cyc, d1_ret;

    int total = 0;
    int bad   = 0;
    int cur_mode = 0;
    int n;

    // reference model state
    int          m_ph, m_drain;
    logic [31:0] m_cyc, m_ret, m_res, m_tnum;
    logic        m_done, m_pass, m_fail, m_to;

    always #5 clk = ~clk;

    riscv_test_monitor #(.MODE(0), .DRAIN_CYCLES(DC), .TIMEOUT_CYCLES(TO)) u0 (
        .i_clk(clk), .i_rst_b(rst_b), .i_enable(enable),
        .i_wb_en(wb_en), .i_wb_addr(wb_addr), .i_wb_data(wb_data),
        .i_st_en(st_en), .i_st_addr(st_addr), .i_st_data(st_data), .i_retire(retire),
        .o_done(d0_done), .o_pass(d0_pass), .o_fail(d0_fail), .o_timeout(d0_to),
        .o_testnum(d0_tnum), .o_cycle_cnt(d0_cyc), .o_retire_cnt(d0_ret));

    riscv_test_monitor #(.MODE(1), .DRAIN_CYCLES(DC), .TIMEOUT_CYCLES(TO)) u1 (
        .i_clk(clk), .i_rst_b(rst_b), .i_enable(enable),
        .i_wb_en(wb_en), .i_wb_addr(wb_addr), .i_wb_data(wb_data),
        .i_st_en(st_en), .i_st_addr(st_addr), .i_st_data(st_data), .i_retire(retire),
        .o_done(d1_done), .o_pass(d1_pass), .o_fail(d1_fail), .o_timeout(d1_to),
        .o_testnum(d1_tnum), .o_cycle_cnt(d1_cyc), .o_retire_cnt(d1_ret));

    wire        w_done = (cur_mode != 0) ? d1_done : d0_done;
    wire        w_pass = (cur_mode != 0) ? d1_pass : d0_pass;
    wire        w_fail = (cur_mode != 0) ? d1_fail : d0_fail;
    wire        w_to   = (cur_mode != 0) ? d1_to   : d0_to;
    wire [31:0] w_tnum = (cur_mode != 0) ? d1_tnum : d0_tnum;
    wire [31:0] w_cyc  = (cur_mode != 0) ? d1_cyc  : d0_cyc;
    wire [31:0] w_ret  = (cur_mode != 0) ? d1_ret  : d0_ret;

    task automatic model_clear();
        m_ph = P_IDLE; m_drain = 0; m_cyc = 0; m_ret = 0; m_res = 0; m_tnum = 0;
        m_done = 0; m_pass = 0; m_fail = 0; m_to = 0;
    endtask

    // Advances the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        logic trig, late;
        if (!rst_b) begin
            model_clear();
            return;
        end
        if (m_ph == P_DONE || m_ph == P_TOUT) return;
        if (wb_en && wb_addr == 5'd27) m_res  = wb_data;
        if (wb_en && wb_addr == 5'd3)  m_tnum = wb_data;
        if (m_ph == P_IDLE) begin
            if (enable) m_ph = P_RUN;
            return;
        end
        if (!enable) return;
        late = (m_cyc >= TO - 1);
        if (m_cyc != 32'hFFFF_FFFF) m_cyc = m_cyc + 1;
        if (retire && m_ret != 32'hFFFF_FFFF) m_ret = m_ret + 1;
        trig = (cur_mode != 0) ? (st_en && st_addr == 32'h10 && st_data == 32'd1)
                               : (wb_en && wb_addr == 5'd26 && wb_data == 32'd1);
        if (m_ph == P_RUN && trig) begin
            m_ph = P_DRAIN;
            m_drain = DC;
        end else if (late) begin
            m_ph = P_TOUT; m_done = 1; m_to = 1;
        end else if (m_ph == P_DRAIN) begin
            m_drain = m_drain - 1;
            if (m_drain == 0) begin
                m_ph = P_DONE; m_done = 1;
                m_pass = (cur_mode != 0) ? 1'b1 : (m_res == 32'd1);
                m_fail = !m_pass;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        assert (act === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, act, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".done"},    32'(w_done), 32'(m_done));
        chk({tag, ".pass"},    32'(w_pass), 32'(m_pass));
        chk({tag, ".fail"},    32'(w_fail), 32'(m_fail));
        chk({tag, ".timeout"}, 32'(w_to),   32'(m_to));
        chk({tag, ".testnum"}, w_tnum, m_tnum);
        chk({tag, ".cycle"},   w_cyc,  m_cyc);
        chk({tag, ".retire"},  w_ret,  m_ret);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        wb_en = 0; st_en = 0; retire = 0;
    endtask

    task automatic ticks(input int k);
        for (int i = 0; i < k; i++) tick();
    endtask

    task automatic do_reset();
        rst_b = 0; enable = 0;
        tick();
        rst_b = 1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        wb_en = 1; wb_addr = a; wb_data = d;
        tick();
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        st_en = 1; st_addr = a; st_data = d;
        tick();
    endtask

    task automatic run_until_done(output int cnt);
        cnt = 0;
        while (!w_done && cnt < 6000) begin
            tick();
            cnt++;
        end
    endtask

    task automatic random_run(input int mode);
        int r;
        cur_mode = mode;
        do_reset();
        for (int c = 0; c < 300; c++) begin
            enable = ($urandom % 8) != 0;
            retire = $urandom % 2;
            r = $urandom % 10;
            if (r < 3) begin
                wb_en = 1;
                case ($urandom % 5)
                    0: wb_addr = 5'd0;
                    1: wb_addr = 5'd3;
                    2: wb_addr = 5'd26;
                    3: wb_addr = 5'd27;
                    default: wb_addr = 5'($urandom);
                endcase
                wb_data = $urandom % 3;
            end
            if (r >= 7) begin
                st_en = 1;
                st_addr = ($urandom % 2) ? 32'h10 : 32'h14;
                st_data = $urandom % 3;
            end
            tick();
            check_all("rand");
        end
    endtask

    initial begin
        rst_b = 0; enable = 0; wb_en = 0; st_en = 0; retire = 0;
        wb_addr = 0; wb_data = 0; st_addr = 0; st_data = 0;
        model_clear();

        // reset state
        cur_mode = 0;
        do_reset();
        check_all("reset");

        // MODE 0 pass: verdict exactly DC edges after the trigger edge
        enable = 1;
        tick();
        wr(5'd3, 32'd5);
        wr(5'd27, 32'd1);
        ticks(97);
        retire = 1; tick();
        wr(5'd26, 32'd1);
        ticks(DC - 1);
        chk("pass.done_early", 32'(w_done), 32'd0);
        tick();
        chk("pass.done", 32'(w_done), 32'd1);
        chk("pass.pass", 32'(w_pass), 32'd1);
        chk("pass.fail", 32'(w_fail), 32'd0);
        chk("pass.testnum", w_tnum, 32'd5);
        check_all("pass");

        // MODE 0 fail, testnum frozen after verdict
        do_reset();
        enable = 1;
        tick();
        wr(5'd27, 32'd0);
        wr(5'd3, 32'd7);
        wr(5'd26, 32'd1);
        ticks(DC);
        chk("fail.fail", 32'(w_fail), 32'd1);
        chk("fail.pass", 32'(w_pass), 32'd0);
        wr(5'd3, 32'd9);
        chk("fail.testnum", w_tnum, 32'd7);
        check_all("fail");

        // timeout with no trigger
        do_reset();
        enable = 1;
        run_until_done(n);
        chk("tout.edges", 32'(n), 32'd3001);
        chk("tout.timeout", 32'(w_to), 32'd1);
        chk("tout.cycle", w_cyc, 32'd3000);
        check_all("tout");

        // 50 disabled cycles push the timeout out by 50
        do_reset();
        enable = 1;
        ticks(1000);
        enable = 0;
        ticks(50);
        enable = 1;
        run_until_done(n);
        chk("tout_gap.edges", 32'(n + 1050), 32'd3051);
        chk("tout_gap.cycle", w_cyc, 32'd3000);
        check_all("tout_gap");

        // MODE 1: wrong data / wrong address must not trigger
        cur_mode = 1;
        do_reset();
        enable = 1;
        tick();
        store(32'h10, 32'd2);
        store(32'h14, 32'd1);
        ticks(DC + 2);
        chk("st.no_trig", 32'(w_done), 32'd0);
        store(32'h10, 32'd1);
        ticks(DC);
        chk("st.pass", 32'(w_pass), 32'd1);
        check_all("st");

        // reset in the middle of DRAIN, then a clean run
        cur_mode = 0;
        do_reset();
        enable = 1;
        tick();
        wr(5'd3, 32'd2);
        wr(5'd27, 32'd1);
        wr(5'd26, 32'd1);
        ticks(4);
        check_all("drain_mid");
        rst_b = 0;
        tick();
        rst_b = 1;
        chk("rst_drain.done", 32'(w_done), 32'd0);
        chk("rst_drain.cycle", w_cyc, 32'd0);
        chk("rst_drain.testnum", w_tnum, 32'd0);
        tick();
        wr(5'd3, 32'd4);
        wr(5'd27, 32'd1);
        wr(5'd26, 32'd1);
        ticks(DC);
        chk("rst_clean.pass", 32'(w_pass), 32'd1);
        chk("rst_clean.testnum", w_tnum, 32'd4);
        check_all("rst_clean");

        // trigger on the last cycle before timeout: DRAIN first, then timeout wins
        do_reset();
        enable = 1;
        tick();
        wr(5'd27, 32'd1);
        ticks(2998);
        chk("edge.cycle", w_cyc, 32'd2999);
        wr(5'd26, 32'd1);
        chk("edge.done_drain", 32'(w_done), 32'd0);
        tick();
        chk("edge.timeout", 32'(w_to), 32'd1);
        chk("edge.pass", 32'(w_pass), 32'd0);
        check_all("edge");

        for (int k = 0; k < 3; k++) random_run(0);
        for (int k = 0; k < 3; k++) random_run(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/riscv_test_monitor.md
RISCV_TEST_MONITOR -- requirements
Module: riscv_test_monitor

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width of writeback and store buses.
REQ-002 SHALL have parameter MODE, default 0; 0 = register-flag test end, 1 = memory-store test end.
REQ-003 SHALL have parameters END_REG=26, RES_REG=27, NUM_REG=3; register indices of end flag, result, test number; END_REG != RES_REG; none is 0.
REQ-004 SHALL have parameter END_ADDR, default 32'h10, byte address of the end-flag store in MODE 1.
REQ-005 SHALL have parameters DRAIN_CYCLES=10 (range 1..255), TIMEOUT_CYCLES=3000 (>= 2), CNT_W=32.
REQ-006 clk  in  1  sole clock; all logic on rising edge.
REQ-007 rst_b  in  1  reset; synchronous, active-low.
REQ-008 enable  in  1  monitor run enable; counters and state advance only while high.
REQ-009 wb_en, wb_addr, wb_data  in  1/5/XLEN  register-file write port.
REQ-010 st_en, st_addr, st_data  in  1/XLEN/XLEN  data-memory store port.
REQ-011 retire  in  1  one instruction retired this cycle.
REQ-012 done, pass, fail, timeout  out  1 each  sticky end status.
REQ-013 testnum  out  XLEN  last value written to NUM_REG.
REQ-014 cycle_cnt, retire_cnt  out  CNT_W each  enabled-cycle and retired-instruction counts.

Function
REQ-015 SHALL implement states IDLE, RUN, DRAIN, DONE, TOUT.
REQ-016 IDLE -> RUN on the first cycle enable=1; no counting in IDLE.
REQ-017 In RUN/DRAIN with enable=1, cycle_cnt SHALL increment by 1 per cycle, saturating at all-ones; retire_cnt SHALL increment when retire=1, saturating.
REQ-018 enable=0 in RUN/DRAIN SHALL freeze state, counters and drain count; shadow captures continue.
REQ-019 Shadow result and testnum SHALL update on wb_en with wb_addr==RES_REG / NUM_REG in IDLE, RUN, DRAIN; writes with wb_addr==0 SHALL be ignored; no updates in DONE/TOUT.
REQ-020 End trigger, MODE 0: wb_en && wb_addr==END_REG && wb_data==1 in RUN.
REQ-021 End trigger, MODE 1: st_en && st_addr==END_ADDR && st_data==1 in RUN.
REQ-022 RUN -> DRAIN on end trigger (registered next edge); drain counter loads DRAIN_CYCLES.
REQ-023 DRAIN SHALL decrement drain counter each enabled cycle; at 0 -> DONE, i.e. DONE entered exactly DRAIN_CYCLES enabled cycles after DRAIN entry.
REQ-024 On DONE entry: done=1; MODE 0: pass=(result==1), fail=~pass; MODE 1: pass=1, fail=0.
REQ-025 In RUN or DRAIN, when cycle_cnt==TIMEOUT_CYCLES-1 and enable=1 -> TOUT next edge: done=1, timeout=1, pass=0, fail=0.
REQ-026 End trigger and timeout condition in the same RUN cycle: end trigger wins (-> DRAIN); timeout still applies during DRAIN.
REQ-027 DONE and TOUT SHALL be terminal until reset; all outputs held.
REQ-028 Result write in the same cycle as end trigger SHALL be captured before pass/fail evaluation.
REQ-029 testnum SHALL reflect the shadow register combinationally-free (registered output).

Reset
REQ-030 rst_b=0 at a clock edge SHALL force IDLE, all outputs, counters, shadows and drain counter to 0, from any state, including mid-DRAIN.
REQ-031 First cycle after rst_b returns high SHALL behave as IDLE regardless of prior state.

Verification
REQ-032 MODE 0: enable=1, wb x3<=5, x27<=1, then x26<=1 at cycle 100 -> done=1, pass=1, fail=0, testnum=5 at cycle 111 (DRAIN_CYCLES=10).
REQ-033 MODE 0: x27<=0, x3<=7, x26<=1 -> done=1, fail=1, pass=0, testnum=7; later x3 writes leave testnum=7.
REQ-034 No end trigger, TIMEOUT_CYCLES=3000 -> timeout=1, done=1 with cycle_cnt=3000; enable low for 50 cycles mid-run delays timeout by exactly 50 cycles.
REQ-035 MODE 1: store 1 to 32'h10 -> pass=1 after drain; store 2 to 32'h10 or 1 to 32'h14 -> no trigger.
REQ-036 rst_b=0 for one cycle during DRAIN -> all outputs 0, IDLE; subsequent clean test completes with correct pass.
REQ-037 End trigger on cycle TIMEOUT_CYCLES-1 -> DRAIN entered; with drain extending past timeout point, timeout=1 wins and pass=0.
